// File: rtl/tpu_pkg.sv
// Shared types and defaults for the systolic tile controller: FSM state encoding,
// the per-state output phase helper, and default array/accumulator sizes.
package tpu_pkg;

  localparam int DEF_ARRAY_DIM = 32;
  localparam int DEF_ACC_DEPTH = 128;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LOAD_W,
    LOAD_A,
    COMPUTE,
    DONE
  } state_t;

  typedef struct packed {
    logic load_weights;
    logic load_act;
    logic compute;
    logic busy;
    logic done;
  } phase_t;

  // Control strobes that depend only on the FSM state.
  function automatic phase_t phase_of(input state_t s);
    phase_t p;
    p              = '0;
    p.load_weights = (s == LOAD_W);
    p.load_act     = (s == LOAD_A);
    p.compute      = (s == COMPUTE);
    p.busy         = (s != IDLE);
    p.done         = (s == DONE);
    return p;
  endfunction

endpackage

// File: rtl/acc_addr_gen.sv
// Accumulator address/mask generator for one tile: maps the compute counter k to
// the drained output row i = k-N, its write address, column mask and read-ahead.
module acc_addr_gen #(
  parameter int N  = 4,
  parameter int AW = 7,
  parameter int CW = 17,
  parameter int YW = 9
) (
  input  logic          active,
  input  logic          hold,
  input  logic [CW-1:0] k,
  input  logic [CW-1:0] base,
  input  logic [CW-1:0] h,
  input  logic [YW-1:0] y,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [N-1:0]  mask,
  output logic          rd,
  output logic          wr
);

  localparam logic [CW-1:0] NK  = CW'(N);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] i;
  logic [CW-1:0] last_i;
  logic          wr_win;
  logic          rd_win;

  assign i      = k - NK;
  assign last_i = h + NK - CW'(2);

  // At k = N-1 the subtraction wraps, so i+1 lands on 0 for the first read-ahead.
  assign wr_win = active && (k >= NK) && (i <= last_i);
  assign rd_win = active && (y != '0) && (k + ONE >= NK) && (i + ONE <= last_i);

  // Address and mask follow the frozen k during a stall; only the strobes drop.
  assign wr      = wr_win && !hold;
  assign rd      = rd_win && !hold;
  assign wr_addr = wr_win ? AW'(base + i) : '0;
  assign rd_addr = rd_win ? AW'(base + i + ONE) : '0;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    localparam logic [CW-1:0] J = CW'(gi);
    assign mask[gi] = wr_win && (i >= J) && ((i - J) < h);
  end

endmodule

// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for an NxN weight-stationary systolic array and its accumulator.
// Optional perf counters are enabled with SYSTOLIC_TILE_CTRL_PERF_CNT_EN.
module systolic_tile_ctrl
  import tpu_pkg::*;
#(
  parameter int ARRAY_DIM = DEF_ARRAY_DIM,
  parameter int ACC_DEPTH = DEF_ACC_DEPTH,
  parameter int DIM_W     = 9,
  localparam int AW       = $clog2(ACC_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DIM_W-1:0]     h_dim_i,
  input  logic [DIM_W-1:0]     w_dim_i,
  input  logic                 fifo_full_i,
  input  logic                 weight_valid_i,
  input  logic                 act_rdy_i,
  input  logic                 stall_i,
  output logic                 load_weights_o,
  output logic                 load_act_o,
  output logic                 mac_en_o,
  output logic                 acc_rd_o,
  output logic                 acc_wr_o,
  output logic                 acc_add_o,
  output logic [AW-1:0]        acc_rd_addr_o,
  output logic [AW-1:0]        acc_wr_addr_o,
  output logic [ARRAY_DIM-1:0] acc_mask_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
`ifdef SYSTOLIC_TILE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]          perf_busy_o,
  output logic [31:0]          perf_stall_o
`endif
);

  localparam int N     = ARRAY_DIM;
  localparam int LOG_N = $clog2(N);
  localparam int CW    = DIM_W + 8;
  localparam int PW    = 2 * DIM_W + 2;

  state_t             state_reg;
  state_t             state_next;
  phase_t             phase;
  logic [DIM_W-1:0]   h_reg;
  logic [DIM_W-1:0]   t_reg;
  logic [DIM_W-1:0]   x_reg;
  logic [DIM_W-1:0]   y_reg;
  logic [CW-1:0]      base_reg;
  logic [CW-1:0]      k_reg;
  logic [LOG_N-1:0]   beat_reg;
  logic               err_reg;

  logic [DIM_W:0]     t_calc;
  logic [PW-1:0]      tile_rows;
  logic               dims_bad;
  logic               start_ok;
  logic [CW-1:0]      h_cw;
  logic               last_beat;
  logic               last_k;
  logic               last_y;
  logic               last_tile;

  // Tile count and accumulator footprint are judged on the raw inputs at start.
  assign t_calc    = ({1'b0, w_dim_i} + (DIM_W+1)'(N - 1)) >> LOG_N;
  assign tile_rows = PW'(t_calc) * PW'(h_dim_i);
  assign dims_bad  = (h_dim_i == '0) || (w_dim_i == '0) || (tile_rows > PW'(ACC_DEPTH));
  assign start_ok  = (state_reg == IDLE) && start_i && !dims_bad;

  assign h_cw      = CW'(h_reg);
  assign last_beat = weight_valid_i && (beat_reg == LOG_N'(N - 1));
  assign last_k    = (k_reg == h_cw + CW'(2 * N - 2));
  assign last_y    = (y_reg == t_reg - DIM_W'(1));
  assign last_tile = last_y && (x_reg == t_reg - DIM_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = FILL;
      FILL:    if (fifo_full_i) state_next = LOAD_W;
      LOAD_W:  if (last_beat) state_next = LOAD_A;
      LOAD_A:  if (act_rdy_i) state_next = COMPUTE;
      COMPUTE: if (!stall_i && last_k) state_next = last_tile ? DONE : LOAD_W;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    phase          = phase_of(state_reg);
    load_weights_o = phase.load_weights;
    load_act_o     = phase.load_act;
    mac_en_o       = phase.compute && !stall_i;
    acc_add_o      = (y_reg != '0);
    busy_o         = phase.busy;
    done_o         = phase.done || err_reg;
    err_o          = err_reg;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_reg    <= '0;
      t_reg    <= '0;
      x_reg    <= '0;
      y_reg    <= '0;
      base_reg <= '0;
      k_reg    <= '0;
      beat_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      err_reg <= (state_reg == IDLE) && start_i && dims_bad;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            h_reg    <= h_dim_i;
            t_reg    <= t_calc[DIM_W-1:0];
            x_reg    <= '0;
            y_reg    <= '0;
            base_reg <= '0;
            k_reg    <= '0;
            beat_reg <= '0;
          end
        end
        LOAD_W: begin
          if (weight_valid_i) beat_reg <= last_beat ? '0 : beat_reg + LOG_N'(1);
        end
        COMPUTE: begin
          if (!stall_i) begin
            if (last_k) begin
              k_reg <= '0;
              // y is the inner tile loop; each new x column moves the base down H rows.
              if (last_tile) begin
                x_reg    <= '0;
                y_reg    <= '0;
                base_reg <= '0;
              end else if (last_y) begin
                y_reg    <= '0;
                x_reg    <= x_reg + DIM_W'(1);
                base_reg <= base_reg + h_cw;
              end else begin
                y_reg <= y_reg + DIM_W'(1);
              end
            end else begin
              k_reg <= k_reg + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  acc_addr_gen #(
    .N  (N),
    .AW (AW),
    .CW (CW),
    .YW (DIM_W)
  ) u_acc_addr_gen (
    .active  (state_reg == COMPUTE),
    .hold    (stall_i),
    .k       (k_reg),
    .base    (base_reg),
    .h       (h_cw),
    .y       (y_reg),
    .wr_addr (acc_wr_addr_o),
    .rd_addr (acc_rd_addr_o),
    .mask    (acc_mask_o),
    .rd      (acc_rd_o),
    .wr      (acc_wr_o)
  );

`ifdef SYSTOLIC_TILE_CTRL_PERF_CNT_EN
  logic [31:0] perf_busy_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_busy_reg  <= '0;
      perf_stall_reg <= '0;
    end else if ((state_reg == IDLE) && start_i) begin
      perf_busy_reg  <= '0;
      perf_stall_reg <= '0;
    end else begin
      if ((state_reg != IDLE) && (perf_busy_reg != '1))
        perf_busy_reg <= perf_busy_reg + 32'd1;
      if ((state_reg == COMPUTE) && stall_i && (perf_stall_reg != '1))
        perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_busy_o  = perf_busy_reg;
  assign perf_stall_o = perf_stall_reg;
`endif

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Directed bench for systolic_tile_ctrl with N=4, ACC_DEPTH=128; expected
// write sequences, masks and cycle counts are hand-derived constants.
module tb_systolic_tile_ctrl;

  localparam int N  = 4;
  localparam int AD = 128;
  localparam int DW = 9;
  localparam int AW = 7;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [DW-1:0] h_dim_i = '0;
  logic [DW-1:0] w_dim_i = '0;
  logic          fifo_full_i = 1'b1;
  logic          weight_valid_i = 1'b1;
  logic          act_rdy_i = 1'b1;
  logic          stall_i = 1'b0;
  logic          load_weights_o, load_act_o, mac_en_o, acc_rd_o, acc_wr_o, acc_add_o;
  logic [AW-1:0] acc_rd_addr_o, acc_wr_addr_o;
  logic [N-1:0]  acc_mask_o;
  logic          busy_o, done_o, err_o;
`ifdef SYSTOLIC_TILE_CTRL_PERF_CNT_EN
  logic [31:0]   perf_busy_o, perf_stall_o;
`endif

  always #5 clk_i = ~clk_i;

  systolic_tile_ctrl #(.ARRAY_DIM(N), .ACC_DEPTH(AD), .DIM_W(DW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .h_dim_i        (h_dim_i),
    .w_dim_i        (w_dim_i),
    .fifo_full_i    (fifo_full_i),
    .weight_valid_i (weight_valid_i),
    .act_rdy_i      (act_rdy_i),
    .stall_i        (stall_i),
    .load_weights_o (load_weights_o),
    .load_act_o     (load_act_o),
    .mac_en_o       (mac_en_o),
    .acc_rd_o       (acc_rd_o),
    .acc_wr_o       (acc_wr_o),
    .acc_add_o      (acc_add_o),
    .acc_rd_addr_o  (acc_rd_addr_o),
    .acc_wr_addr_o  (acc_wr_addr_o),
    .acc_mask_o     (acc_mask_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o)
`ifdef SYSTOLIC_TILE_CTRL_PERF_CNT_EN
    ,
    .perf_busy_o    (perf_busy_o),
    .perf_stall_o   (perf_stall_o)
`endif
  );

  typedef struct {int cyc; int addr; int mask; int add;} wr_t;
  typedef struct {int cyc; int addr;} rd_t;
  typedef struct {int addr; int mask; int wr; int mac;} st_t;

  wr_t wr_q[$];
  rd_t rd_q[$];
  st_t st_q[$];
  int  cyc_cnt = 0, busy_cnt = 0, lw_cnt = 0, beat_cnt = 0, mac_cnt = 0, done_cnt = 0, err_cnt = 0;

  // Passive monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      cyc_cnt++;
      if (busy_o) busy_cnt++;
      if (load_weights_o) lw_cnt++;
      if (load_weights_o && weight_valid_i) beat_cnt++;
      if (mac_en_o) mac_cnt++;
      if (done_o) done_cnt++;
      if (err_o) err_cnt++;
      if (acc_wr_o) wr_q.push_back('{cyc_cnt, int'(acc_wr_addr_o), int'(acc_mask_o), int'(acc_add_o)});
      if (acc_rd_o) rd_q.push_back('{cyc_cnt, int'(acc_rd_addr_o)});
      if (busy_o && stall_i) st_q.push_back('{int'(acc_wr_addr_o), int'(acc_mask_o), int'(acc_wr_o), int'(mac_en_o)});
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int s_wr, s_rd, s_st, s_busy, s_lw, s_beat, s_mac, s_done, s_err;

  task automatic snap();
    s_wr = wr_q.size(); s_rd = rd_q.size(); s_st = st_q.size();
    s_busy = busy_cnt; s_lw = lw_cnt; s_beat = beat_cnt; s_mac = mac_cnt;
    s_done = done_cnt; s_err = err_cnt;
  endtask

  // One full operation; caller is positioned just after a rising edge.
  task automatic run_op(input int h, input int k, input int gap_s, input int gap_n,
                        input int stall_k, input int stall_n);
    int  lw, kc, st, cyc;
    bit  la_prev, fin;
    snap();
    h_dim_i = DW'(h); w_dim_i = DW'(k); start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    lw = 0; kc = -1; st = 0; cyc = 0; la_prev = 0; fin = 0;
    while (!fin && cyc < 2000) begin
      weight_valid_i = 1'b1;
      if (load_weights_o) begin
        if (lw >= gap_s && lw < gap_s + gap_n) weight_valid_i = 1'b0;
        lw++;
      end
      if (la_prev) kc = 0;
      stall_i = 1'b0;
      if (kc >= 0) begin
        if (kc == stall_k && st < stall_n) begin
          stall_i = 1'b1;
          st++;
        end else begin
          kc++;
        end
      end
      la_prev = load_act_o;
      fin = done_o;
      @(posedge clk_i); #1;
      cyc++;
    end
    stall_i = 1'b0;
    weight_valid_i = 1'b1;
    check("op_timeout", fin, 1);
    repeat (2) @(posedge clk_i);
    #1;
    $display("op h=%0d k=%0d writes=%0d reads=%0d busy=%0d done=%0d",
             h, k, wr_q.size() - s_wr, rd_q.size() - s_rd, busy_cnt - s_busy, done_cnt - s_done);
  endtask

  // Single-tile H=4 sequence: addresses 0..6, masks 0001..1000, overwrite only.
  task automatic check_single_tile(input string tag);
    int exp_m[7] = '{1, 3, 7, 15, 14, 12, 8};
    check({tag, "_wr_count"}, wr_q.size() - s_wr, 7);
    for (int n = 0; n < 7 && s_wr + n < wr_q.size(); n++) begin
      check({tag, "_wr_addr"}, wr_q[s_wr + n].addr, n);
      check({tag, "_wr_mask"}, wr_q[s_wr + n].mask, exp_m[n]);
      check({tag, "_wr_add"},  wr_q[s_wr + n].add, 0);
    end
    check({tag, "_rd_count"}, rd_q.size() - s_rd, 0);
    check({tag, "_done"}, done_cnt - s_done, 1);
    check({tag, "_mac"}, mac_cnt - s_mac, 11);
  endtask

  task automatic err_case(input string tag, input int h, input int k);
    snap();
    h_dim_i = DW'(h); w_dim_i = DW'(k); start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check({tag, "_err"}, err_o, 1);
    check({tag, "_done"}, done_o, 1);
    check({tag, "_busy"}, busy_o, 0);
    @(posedge clk_i); #1;
    check({tag, "_err_low"}, err_o, 0);
    check({tag, "_done_low"}, done_o, 0);
    repeat (3) @(posedge clk_i);
    #1;
    check({tag, "_no_wr"}, wr_q.size() - s_wr, 0);
    check({tag, "_err_cnt"}, err_cnt - s_err, 1);
    $display("err h=%0d k=%0d err_pulses=%0d", h, k, err_cnt - s_err);
  endtask

  initial begin
    int m3[6] = '{1, 3, 7, 14, 12, 8};
    int tb_base[4] = '{0, 0, 3, 3};
    int tb_add[4] = '{0, 1, 0, 1};
    int guard;

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("reset_outs", {load_weights_o, load_act_o, mac_en_o, acc_rd_o, acc_wr_o, acc_add_o,
                         acc_rd_addr_o, acc_wr_addr_o, acc_mask_o, busy_o, done_o, err_o}, 0);

    // One tile, no backpressure.
    run_op(4, 4, 0, 0, -1, 0);
    check_single_tile("t1");
    check("t1_busy", busy_cnt - s_busy, 18);
    check("t1_lw", lw_cnt - s_lw, 4);

    // Four tiles: x outer, y inner; x=1 tiles start at base H=3.
    run_op(3, 8, 0, 0, -1, 0);
    check("t2_wr_count", wr_q.size() - s_wr, 24);
    for (int n = 0; n < 24 && s_wr + n < wr_q.size(); n++) begin
      check("t2_wr_addr", wr_q[s_wr + n].addr, tb_base[n / 6] + n % 6);
      check("t2_wr_mask", wr_q[s_wr + n].mask, m3[n % 6]);
      check("t2_wr_add",  wr_q[s_wr + n].add, tb_add[n / 6]);
    end
    check("t2_rd_count", rd_q.size() - s_rd, 12);
    for (int r = 0; r < 12 && s_rd + r < rd_q.size(); r++) begin
      int w;
      w = ((r < 6) ? 6 : 18) + r % 6;
      check("t2_rd_addr", rd_q[s_rd + r].addr, ((r < 6) ? 0 : 3) + r % 6);
      if (s_wr + w < wr_q.size())
        check("t2_rd_lead", rd_q[s_rd + r].cyc, wr_q[s_wr + w].cyc - 1);
    end
    check("t2_done", done_cnt - s_done, 1);
    check("t2_lw", lw_cnt - s_lw, 16);
    check("t2_busy", busy_cnt - s_busy, 62);

    // Weight-valid gap of 3 cycles in LOAD_W.
    run_op(4, 4, 2, 3, -1, 0);
    check_single_tile("t3");
    check("t3_lw_cycles", lw_cnt - s_lw, 7);
    check("t3_beats", beat_cnt - s_beat, 4);
    check("t3_busy", busy_cnt - s_busy, 21);

    // Stall for 5 cycles at k=6 (i=2).
    run_op(4, 4, 0, 0, 6, 5);
    check_single_tile("t4");
    check("t4_busy", busy_cnt - s_busy, 23);
    check("t4_stall_cnt", st_q.size() - s_st, 5);
    for (int n = s_st; n < st_q.size(); n++) begin
      check("t4_st_addr", st_q[n].addr, 2);
      check("t4_st_mask", st_q[n].mask, 7);
      check("t4_st_wr",   st_q[n].wr, 0);
      check("t4_st_mac",  st_q[n].mac, 0);
    end
    if (s_wr + 2 < wr_q.size())
      check("t4_wr_gap", wr_q[s_wr + 2].cyc - wr_q[s_wr + 1].cyc, 6);

    // Illegal dimensions.
    err_case("e_h0", 0, 4);
    err_case("e_k0", 4, 0);
    err_case("e_big", 100, 8);

    // T*H == ACC_DEPTH is legal; abort it with reset mid-compute.
    h_dim_i = DW'(64); w_dim_i = DW'(8); start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("r_start_busy", busy_o, 1);
    check("r_start_err", err_o, 0);
    guard = 0;
    while (!mac_en_o && guard < 200) begin
      @(posedge clk_i); #1;
      guard++;
    end
    check("r_reach_compute", mac_en_o, 1);
    repeat (5) @(posedge clk_i);
    #1;
    rst_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; start_i = 1'b0;
    check("r_outs_zero", {load_weights_o, load_act_o, mac_en_o, acc_rd_o, acc_wr_o, acc_add_o,
                          acc_rd_addr_o, acc_wr_addr_o, acc_mask_o, busy_o, done_o, err_o}, 0);
    @(posedge clk_i); #1;
    check("r_start_dropped", busy_o, 0);
    $display("reset mid-compute after %0d cycles", guard);

    run_op(4, 4, 0, 0, -1, 0);
    check_single_tile("t6");
    check("t6_busy", busy_cnt - s_busy, 18);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/systolic_tile_ctrl.md
SYSTOLIC_TILE_CTRL -- requirements
Module: systolic_tile_ctrl

Interface
REQ-001 SHALL have parameter ARRAY_DIM, default 32, meaning systolic array edge N; legal values are powers of two from 4 to 64.
REQ-002 SHALL have parameter ACC_DEPTH, default 128, meaning accumulator rows; AW = $clog2(ACC_DEPTH).
REQ-003 SHALL have parameter DIM_W, default 9, meaning the width of the dimension inputs.
REQ-004 SHALL have ports, one per line, as listed below; there is one clock, and reset is synchronous and active-high.
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start pulse; ignored while busy_o=1
h_dim_i  in  DIM_W  activation rows H, sampled at start
w_dim_i  in  DIM_W  square weight dim K, sampled at start
fifo_full_i  in  1  weight FIFO holds a full tile
weight_valid_i  in  1  weight FIFO output valid
act_rdy_i  in  1  activations staged
stall_i  in  1  downstream backpressure, freezes compute
load_weights_o  out  1  shift weights into array
load_act_o  out  1  feed activations
mac_en_o  out  1  array computes this cycle
acc_rd_o  out  1  accumulator read enable
acc_wr_o  out  1  accumulator write enable
acc_add_o  out  1  write = read + partial sum (else overwrite)
acc_rd_addr_o  out  AW  read address
acc_wr_addr_o  out  AW  write address
acc_mask_o  out  N  per-column write mask
busy_o  out  1  operation in progress
done_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle pulse on illegal dims

Function
REQ-005 SHALL implement states IDLE, FILL, LOAD_W, LOAD_A, COMPUTE, DONE.
REQ-006 SHALL move IDLE->FILL on start_i; FILL->LOAD_W when fifo_full_i=1; LOAD_W->LOAD_A after N weight_valid_i beats; LOAD_A->COMPUTE when act_rdy_i=1.
REQ-007 SHALL hold the LOAD_W beat counter whenever weight_valid_i=0, keeping load_weights_o=1.
REQ-008 SHALL set tiles T = ceil(K/N); iterate y tile 0..T-1 inner and x tile 0..T-1 outer; per-tile base = x*H.
REQ-009 SHALL advance compute counter k from 0 each COMPUTE cycle, freezing k and forcing mac_en_o=0, acc_wr_o=0 and acc_rd_o=0 while stall_i=1.
REQ-010 SHALL, with row index i = k-N, assert acc_wr_o for 0 <= i <= H+N-2 with acc_wr_addr_o = base+i.
REQ-011 SHALL set acc_mask_o bit j iff j <= i and i-j < H; this covers partial ramp-up, full rows and the reverse-partial tail.
REQ-012 SHALL assert acc_rd_o one cycle ahead of each write with acc_rd_addr_o = base+i+1, only when y>0.
REQ-013 SHALL hold acc_add_o = (y>0) for the whole tile.
REQ-014 SHALL, after the write at i = H+N-2, go to LOAD_W for the next tile, or to DONE after tile (T-1,T-1).
REQ-015 SHALL, in DONE, pulse done_o for one cycle and return to IDLE.
REQ-016 SHALL reject H=0, K=0 or T*H > ACC_DEPTH at start: pulse err_o and done_o in the next cycle and stay IDLE, with no accumulator access.
REQ-017 SHALL drive busy_o=1 in all states except IDLE.
REQ-018 SHALL ignore a start_i that coincides with DONE.
REQ-019 SHALL give stall_i no effect outside COMPUTE.

Reset
REQ-020 SHALL on rst_i, including mid-operation, enter IDLE and clear all counters, tile indices and sampled dims.
REQ-021 SHALL drive every output to 0 in the cycle after rst_i; a start_i asserted during rst_i is dropped.

Configuration
REQ-022 SHALL, with macro SYSTOLIC_TILE_CTRL_PERF_CNT_EN defined, add outputs perf_busy_o[31:0] and perf_stall_o[31:0]: cycles with busy_o=1, and COMPUTE cycles with stall_i=1, cleared on start and by rst_i, saturating at all-ones.
REQ-023 SHALL, without SYSTOLIC_TILE_CTRL_PERF_CNT_EN, omit these ports and their logic entirely.

Structure
REQ-024 SHALL place the state enum, the output-phase helper and the default ARRAY_DIM/ACC_DEPTH constants in shared package tpu_pkg.
REQ-025 SHALL implement the REQ-010..REQ-012 address and mask generation in sub-module acc_addr_gen, which takes k, base, H and y and outputs addr, mask, rd and wr.

Verification
REQ-026 SHALL cover: N=4, H=4, K=4 -> one tile; 7 writes at addresses 0..6; masks 0001,0011,0111,1111,1110,1100,1000; acc_add_o=0; single done_o.
REQ-027 SHALL cover: N=4, H=3, K=8 -> 4 tiles; x=1 writes at base 3; acc_add_o=1 on y=1 tiles; done_o after the 4th tile.
REQ-028 SHALL cover: N=4, H=4, K=4 with weight_valid_i low 3 cycles mid-load -> LOAD_W lasts exactly 7 cycles; 4 beats counted.
REQ-029 SHALL cover: stall_i high 5 cycles at k=6 -> address, mask and k frozen with acc_wr_o=0; sequence resumes unchanged; total COMPUTE cycles +5.
REQ-030 SHALL cover: H=0 -> err_o and done_o pulse 1 cycle after start, no acc_wr_o; also N=4, H=100, K=8, ACC_DEPTH=128 (T*H=200) -> err_o.
REQ-031 SHALL cover: rst_i asserted mid-COMPUTE -> all outputs 0 in the next cycle; a new start then completes normally.
